// File: rtl/ub_pkg.sv
// Shared types and helpers for the unified stream buffer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ub_pkg;

  // Read-side FSM states
  typedef enum logic {
    UB_IDLE   = 1'b0,
    UB_STREAM = 1'b1
  } ub_state_t;

  localparam int UB_DATA_W = 32;
  localparam int UB_LANES  = 4;

  // Word address of lane offset from base, wrapped to a power-of-two depth.
  // Callers truncate the result to their own address width.
  function automatic logic [31:0] lane_addr(input logic [31:0] base,
                                            input logic [31:0] offs,
                                            input logic [31:0] depth);
    return (base + offs) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/ub_read_streamer.sv
// Burst read engine: FSM, cur_addr/remain counters and registered beat output.
// Latency: beat 0 valid one cycle after an accepted rd_req; back-to-back beats while out_ready is high.
// Backpressure: out_valid/out_data hold until out_ready; rd_req is ignored while a burst is active.
module ub_read_streamer
  import ub_pkg::*;
#(
  parameter int DATA_W = UB_DATA_W,
  parameter int DEPTH  = 64,
  parameter int LANES  = UB_LANES,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic [CNT_W-1:0]        rd_beats,
  input  logic                    out_ready,
  input  logic [LANES*DATA_W-1:0] fetch_data,
  output logic [ADDR_W-1:0]       fetch_addr,
  output logic                    rd_busy,
  output logic                    out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    rd_done
);

  ub_state_t               state, state_nxt;
  logic [ADDR_W-1:0]       cur_addr, cur_addr_nxt;
  logic [CNT_W-1:0]        remain, remain_nxt;
  logic                    valid_nxt;
  logic [LANES*DATA_W-1:0] data_nxt;
  logic                    hs;

  assign hs      = out_valid && out_ready;
  assign rd_busy = (state == UB_STREAM);

  // State, counters and output beat register; reset aborts any burst at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= UB_IDLE;
      cur_addr  <= '0;
      remain    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_addr_nxt;
      remain    <= remain_nxt;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
    end
  end

  // Next-state: start burst from IDLE, advance one beat per handshake in STREAM.
  // fetch_addr always points at the beat that would be loaded on this edge.
  always_comb begin
    state_nxt    = state;
    cur_addr_nxt = cur_addr;
    remain_nxt   = remain;
    valid_nxt    = out_valid;
    data_nxt     = out_data;
    rd_done      = 1'b0;
    fetch_addr   = ADDR_W'(lane_addr(32'(cur_addr), 32'(LANES), 32'(DEPTH)));
    case (state)
      UB_IDLE: begin
        fetch_addr = rd_addr;
        if (rd_req && (rd_beats != '0)) begin
          state_nxt    = UB_STREAM;
          cur_addr_nxt = rd_addr;
          remain_nxt   = rd_beats;
          valid_nxt    = 1'b1;
          data_nxt     = fetch_data;
        end
      end
      UB_STREAM: begin
        if (hs) begin
          if (remain == CNT_W'(1)) begin
            rd_done   = 1'b1;
            valid_nxt = 1'b0;
            state_nxt = UB_IDLE;
          end else begin
            cur_addr_nxt = fetch_addr;
            remain_nxt   = remain - CNT_W'(1);
            data_nxt     = fetch_data;
          end
        end
      end
      default: state_nxt = UB_IDLE;
    endcase
  end

endmodule

// File: rtl/ub_stream_buffer.sv
// Unified buffer: LANES-wide vector store, burst vector streaming out under valid/ready.
// Latency: write visible next cycle; first read beat one cycle after rd_req.
// Backpressure: writes always accepted; read beats stall on out_ready low.
// Optional feature: define UB_PRELOAD_EN to reset mem[30..33] to an activation bring-up pattern.
module ub_stream_buffer
  import ub_pkg::*;
#(
  parameter int DATA_W = UB_DATA_W,
  parameter int DEPTH  = 64,
  parameter int LANES  = UB_LANES,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [LANES*DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0]       wr_ptr,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic [CNT_W-1:0]        rd_beats,
  output logic                    rd_busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    rd_done
);

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [ADDR_W-1:0]       fetch_addr;
  logic [LANES*DATA_W-1:0] fetch_data;

`ifdef UB_PRELOAD_EN
  if (DEPTH < 34) begin : g_depth_chk
    $error("ub_stream_buffer: UB_PRELOAD_EN needs DEPTH >= 34");
  end

  function automatic logic [DATA_W-1:0] reset_word(input int idx);
    case (idx)
      30:      return DATA_W'(11);
      31:      return DATA_W'(12);
      32:      return DATA_W'(21);
      33:      return DATA_W'(22);
      default: return '0;
    endcase
  endfunction
`else
  function automatic logic [DATA_W-1:0] reset_word(input int idx);
    return (idx < 0) ? DATA_W'(1) : '0;
  endfunction
`endif

  // Storage array and write pointer; every lane address wraps mod DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= reset_word(j);
      wr_ptr <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++)
        mem[ADDR_W'(lane_addr(32'(wr_addr), 32'(i), 32'(DEPTH)))] <= wr_data[i*DATA_W +: DATA_W];
      wr_ptr <= ADDR_W'(lane_addr(32'(wr_addr), 32'(LANES), 32'(DEPTH)));
    end
  end

  // Asynchronous beat read; a same-edge write is not yet visible, so a beat
  // loaded alongside an overlapping write captures the old words
  always_comb begin
    fetch_data = '0;
    for (int i = 0; i < LANES; i++)
      fetch_data[i*DATA_W +: DATA_W] = mem[ADDR_W'(lane_addr(32'(fetch_addr), 32'(i), 32'(DEPTH)))];
  end

  ub_read_streamer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LANES  (LANES),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_streamer (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_beats   (rd_beats),
    .out_ready  (out_ready),
    .fetch_data (fetch_data),
    .fetch_addr (fetch_addr),
    .rd_busy    (rd_busy),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .rd_done    (rd_done)
  );

endmodule
